mat_mult_sched: RTL
===================

Name: mat_mult_sched

Overview:
- Shares one mat_mult engine among NUM_REQ requesters (e.g. the scaling, projection and inverse stages of the spectral pipeline) using round-robin arbitration.
- Latches the granted requester's dimensions and MAC mode, and drives them as the engine's config for the whole job.
- Pulses the engine start, counts produced elements and watches for engine completion or a hang.
- Returns a per-requester done/error pulse.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
SPECTRAL_BANDS, 103, sets DW = $clog2(SPECTRAL_BANDS), the dimension field width
TIMEOUT_CYCLES, 65535, RUN-state cycle limit before abort

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
req  in  NUM_REQ  job request per requester, level
req_rows  in  NUM_REQ*DW  packed mat1 rows-1 per requester (slice i = [i*DW +: DW])
req_cols  in  NUM_REQ*DW  packed mat1 cols-1
req_cols2  in  NUM_REQ*DW  packed mat2 cols-1
req_mode  in  NUM_REQ*3  packed mac_mode
grant  out  NUM_REQ  one-hot owner of engine; held for entire job
job_done  out  NUM_REQ  one-cycle completion pulse to owner
job_err  out  NUM_REQ  one-cycle pulse, coincident with job_done, on count mismatch or timeout
busy  out  1  high in any state but IDLE
mm_start  out  1  one-cycle engine start
mm_rows, mm_cols, mm_cols2  out  DW each  latched config to engine
mm_mode  out  3  latched mac_mode
mm_soft_rst  out  1  one-cycle engine reset request on timeout; top ORs it into the engine's active-high reset
mm_out_valid  in  1  engine output element valid
mm_done  in  1  engine done pulse

Behaviour:
- Reset (async assert, sync deassert at top):
  - All outputs 0; state IDLE; counters 0.
  - RR pointer = NUM_REQ-1, so requester 0 wins first.
- States: IDLE -> START -> RUN -> FINISH -> IDLE.
- IDLE:
  - If |req, the winner is the first set bit searching upward from pointer+1, with wrap.
  - At the clock edge: set grant[winner], latch that requester's rows/cols/cols2/mode into the mm_* registers, update pointer = winner, clear counters, go to START.
  - Requests dropped before grant are ignored; no queuing.
- START:
  - mm_start = 1 for exactly this cycle; go to RUN.
  - mm_* config stays stable from START through FINISH.
- RUN:
  - out_cnt (2*DW bits, saturating) increments on each mm_out_valid.
  - wdog increments every cycle.
  - expected = (mm_rows+1)*(mm_cols2+1), computed once in START and registered.
  - If mm_done: err = (out_cnt + mm_out_valid != expected); go to FINISH.
  - Else if wdog == TIMEOUT_CYCLES-1: err = 1; mm_soft_rst = 1 next cycle; go to FINISH.
  - mm_done and timeout in the same cycle: mm_done wins.
- FINISH (one cycle):
  - job_done[owner] = 1; job_err[owner] = err.
  - grant clears on the same edge that raises job_done, so grant is already 0 while job_done is high.
  - Go to IDLE.
- Latency:
  - req seen in IDLE to grant: 1 cycle.
  - grant to mm_start: same cycle as START (START entered together with grant).
  - mm_done to job_done: 1 cycle.
  - Minimum gap from job_done to the next grant: 1 cycle (IDLE).
- Fairness: a requester holding req after its job_done is served again only after every other active requester has been served.
- Outside RUN:
  - mm_out_valid and mm_done are ignored.
  - A stray mm_done in IDLE does not raise job_done.
- Reset mid-job: grant, mm_start, busy and mm_soft_rst drop immediately and asynchronously; the job is lost with no done pulse.
- Widths:
  - expected is formed as a (2*DW)-bit unsigned product; no truncation.
  - wdog width = $clog2(TIMEOUT_CYCLES+1).

Decomposition:
- Shared package mat_mult_pkg:
  - State encoding localparams (S_IDLE, S_START, S_RUN, S_FINISH).
  - DW derivation and MAC mode code constants, shared with mat_mult users.
- One sub-module, rr_arbiter:
  - Combinational NUM_REQ-wide round-robin pick from req and pointer.
  - Outputs a one-hot winner plus its index.
  - Pointer register stays in mat_mult_sched.

Test Plan:
- Single job: req=3'b001, rows=1, cols=2, cols2=1, mode=2 -> grant=001 next cycle, mm_start one cycle with mm_rows=1, mm_cols2=1, mm_mode=2; 4 mm_out_valid then mm_done -> job_done=001, job_err=0 one cycle later, busy=0 after.
- Contention: req=3'b111 held constantly -> grants in order 001, 010, 100, 001, each separated by job_done plus one IDLE cycle.
- Count mismatch: rows=1, cols2=1 (expects 4), engine model gives 3 mm_out_valid then mm_done -> job_done and job_err both pulse for the owner.
- Timeout: TIMEOUT_CYCLES=16, engine never asserts mm_done -> job_err and job_done after 16 RUN cycles, mm_soft_rst one-cycle pulse, next req granted normally.
- Simultaneous: mm_done asserted on the cycle wdog hits its limit -> no mm_soft_rst, job_err reflects count only.
- Async reset: assert rst=0 mid-RUN between clock edges -> grant, busy and mm_start go 0 immediately; after release, req=3'b110 -> grant=010 (pointer reset).

Source files
------------

// File: rtl/mat_mult_pkg.sv
// Shared definitions for the mat_mult engine and its scheduler.
// State codes, dimension width helper and MAC mode codes.
package mat_mult_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_START  = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam int SPECTRAL_BANDS_DEF = 103;
  localparam int DW_DEF = $clog2(SPECTRAL_BANDS_DEF);

  localparam logic [2:0] MAC_MUL   = 3'd0;
  localparam logic [2:0] MAC_ACC   = 3'd1;
  localparam logic [2:0] MAC_MUL_T = 3'd2;
  localparam logic [2:0] MAC_SCALE = 3'd3;
  localparam logic [2:0] MAC_INV   = 3'd4;

  function automatic int dim_width(input int bands);
    return $clog2(bands);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request above ptr, with wrap.
// Returns one-hot winner and its index; ptr register lives in the caller.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx
);

  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NUM_REQ]) begin
        found = 1'b1;
        gnt[(int'(ptr) + k) % NUM_REQ] = 1'b1;
        idx = IW'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/mat_mult_sched.sv
// Round-robin scheduler sharing one mat_mult engine among requesters.
// Latches job config, starts the engine, checks element count and hangs.
module mat_mult_sched
  import mat_mult_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int SPECTRAL_BANDS = 103,
  parameter int TIMEOUT_CYCLES = 65535,
  localparam int DW = dim_width(SPECTRAL_BANDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*DW-1:0] req_rows,
  input  logic [NUM_REQ*DW-1:0] req_cols,
  input  logic [NUM_REQ*DW-1:0] req_cols2,
  input  logic [NUM_REQ*3-1:0]  req_mode,
  output logic [NUM_REQ-1:0]    grant,
  output logic [NUM_REQ-1:0]    job_done,
  output logic [NUM_REQ-1:0]    job_err,
  output logic                  busy,
  output logic                  mm_start,
  output logic [DW-1:0]         mm_rows,
  output logic [DW-1:0]         mm_cols,
  output logic [DW-1:0]         mm_cols2,
  output logic [2:0]            mm_mode,
  output logic                  mm_soft_rst,
  input  logic                  mm_out_valid,
  input  logic                  mm_done
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = 2 * DW;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]         state;
  logic [IW-1:0]      ptr;
  logic [NUM_REQ-1:0] win_oh;
  logic [IW-1:0]      win_idx;
  logic [CW-1:0]      out_cnt;
  logic [CW-1:0]      expected;
  logic [WW-1:0]      wdog;
  logic [CW-1:0]      rows_p1;
  logic [CW-1:0]      cols2_p1;
  logic [CW:0]        cnt_fin;
  logic               cnt_bad;
  logic               wdog_hit;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .req(req),
    .ptr(ptr),
    .gnt(win_oh),
    .idx(win_idx)
  );

  assign busy     = (state != S_IDLE);
  assign rows_p1  = CW'(mm_rows) + CW'(1);
  assign cols2_p1 = CW'(mm_cols2) + CW'(1);
  // Element arriving with mm_done still belongs to this job
  assign cnt_fin  = {1'b0, out_cnt} + (CW+1)'(mm_out_valid);
  assign cnt_bad  = (cnt_fin != {1'b0, expected});
  assign wdog_hit = (wdog == WW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      ptr         <= IW'(NUM_REQ - 1);
      grant       <= '0;
      job_done    <= '0;
      job_err     <= '0;
      mm_start    <= 1'b0;
      mm_rows     <= '0;
      mm_cols     <= '0;
      mm_cols2    <= '0;
      mm_mode     <= '0;
      mm_soft_rst <= 1'b0;
      out_cnt     <= '0;
      expected    <= '0;
      wdog        <= '0;
    end else begin
      mm_start    <= 1'b0;
      job_done    <= '0;
      job_err     <= '0;
      mm_soft_rst <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (|req) begin
            grant    <= win_oh;
            ptr      <= win_idx;
            mm_rows  <= req_rows[win_idx*DW +: DW];
            mm_cols  <= req_cols[win_idx*DW +: DW];
            mm_cols2 <= req_cols2[win_idx*DW +: DW];
            mm_mode  <= req_mode[win_idx*3 +: 3];
            out_cnt  <= '0;
            wdog     <= '0;
            mm_start <= 1'b1;
            state    <= S_START;
          end
        end
        S_START: begin
          expected <= rows_p1 * cols2_p1;
          state    <= S_RUN;
        end
        S_RUN: begin
          wdog <= wdog + WW'(1);
          if (mm_out_valid && out_cnt != '1)
            out_cnt <= out_cnt + CW'(1);
          if (mm_done) begin
            job_done <= grant;
            job_err  <= cnt_bad ? grant : '0;
            grant    <= '0;
            state    <= S_FINISH;
          end else if (wdog_hit) begin
            job_done    <= grant;
            job_err     <= grant;
            grant       <= '0;
            mm_soft_rst <= 1'b1;
            state       <= S_FINISH;
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule
